// File: rtl/dec_pkg.sv
// Shared definitions for the sequential one-hot operation decoder.
//   - FSM state encoding (idle, direct hold, scan)
//   - request mode constants
//   - ALU operation indices at the default 2-bit selector width
package dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } dec_state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int unsigned OP_AND  = 0;
    localparam int unsigned OP_OR   = 1;
    localparam int unsigned OP_NAND = 2;
    localparam int unsigned OP_XOR  = 3;

endpackage

// File: rtl/dec_onehot.sv
// Combinational index to one-hot converter.
//   index  : binary line index (SEL_W bits)
//   onehot : 2**SEL_W lines, exactly one bit set
module dec_onehot #(
    parameter int unsigned SEL_W = 2
) (
    input  logic [SEL_W-1:0]      index,
    output logic [(1<<SEL_W)-1:0] onehot
);

    always_comb begin
        onehot        = '0;
        onehot[index] = 1'b1;
    end

endmodule

// File: rtl/decodificador_secuencial.sv
// Registered one-hot operation decoder with valid/ready handshake and a
// programmable hold time per line.
//   clk, reset    : rising-edge clock, asynchronous active-high reset
//   dec_enable    : block enable; low aborts any operation
//   dec_mode      : 0 = drive one line, 1 = scan all lines (captured at accept)
//   dec_valid     : request strobe
//   dec_selector  : target / start index (captured at accept)
//   dec_ready     : idle and enabled
//   dec_out       : registered one-hot or zero
//   dec_index     : index currently driven on dec_out
//   dec_busy      : high while a line is being driven
//   dec_done      : one-cycle pulse after normal completion
module decodificador_secuencial
    import dec_pkg::*;
#(
    parameter int unsigned SEL_W       = 2,
    parameter int unsigned HOLD_CYCLES = 1,
    localparam int unsigned OUT_W      = 1 << SEL_W,
    localparam int unsigned CNT_W      = $clog2(HOLD_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_enable,
    input  logic             dec_mode,
    input  logic             dec_valid,
    input  logic [SEL_W-1:0] dec_selector,
    output logic             dec_ready,
    output logic [OUT_W-1:0] dec_out,
    output logic [SEL_W-1:0] dec_index,
    output logic             dec_busy,
    output logic             dec_done
);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_LINE  = SEL_W'(OUT_W - 1);

    dec_state_t       state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [SEL_W-1:0] served_q, served_d;  // lines completed so far in a scan
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load_line;
    logic             clear_line;
    logic [OUT_W-1:0] next_onehot;

    assign dec_ready = (state_q == ST_IDLE) && dec_enable;
    assign dec_out   = out_q;
    assign dec_index = idx_q;
    assign dec_busy  = busy_q;
    assign dec_done  = done_q;

    dec_onehot #(
        .SEL_W (SEL_W)
    ) u_onehot (
        .index  (idx_d),
        .onehot (next_onehot)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        served_d   = served_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load_line  = 1'b0;
        clear_line = 1'b0;

        if (!dec_enable) begin
            // Abort: silent return to idle, no completion pulse.
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            clear_line = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (dec_valid) begin
                        idx_d     = dec_selector;
                        served_d  = '0;
                        cnt_d     = CNT_RELOAD;
                        busy_d    = 1'b1;
                        load_line = 1'b1;
                        state_d   = (dec_mode == MODE_SCAN) ? ST_SCAN : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        clear_line = 1'b1;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (served_q == LAST_LINE) begin
                        clear_line = 1'b1;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        // Natural SEL_W-bit overflow gives the wrap to line 0.
                        idx_d     = idx_q + SEL_W'(1);
                        served_d  = served_q + SEL_W'(1);
                        cnt_d     = CNT_RELOAD;
                        load_line = 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    busy_d     = 1'b0;
                    clear_line = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        out_d = out_q;
        if (clear_line) begin
            out_d = '0;
        end else if (load_line) begin
            out_d = next_onehot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            served_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            served_q <= served_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_decodificador_secuencial.sv
module tb_decodificador_secuencial;

    localparam int unsigned HOLD  = 3;
    localparam int unsigned OUT_W = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       en    = 1'b0;
    logic       mode  = 1'b0;
    logic       valid = 1'b0;
    logic [1:0] sel   = 2'b00;
    logic       ready;
    logic [3:0] out;
    logic [1:0] idx;
    logic       busy;
    logic       done;

    logic       en8    = 1'b0;
    logic       mode8  = 1'b0;
    logic       valid8 = 1'b0;
    logic [2:0] sel8   = 3'b000;
    logic       ready8;
    logic [7:0] out8;
    logic [2:0] idx8;
    logic       busy8;
    logic       done8;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of (line, index) values still to be shown.
    logic [3:0] mq_out[$];
    logic [1:0] mq_idx[$];
    logic       m_done = 1'b0;

    always #5 clk = ~clk;

    decodificador_secuencial #(
        .SEL_W       (2),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dec_enable   (en),
        .dec_mode     (mode),
        .dec_valid    (valid),
        .dec_selector (sel),
        .dec_ready    (ready),
        .dec_out      (out),
        .dec_index    (idx),
        .dec_busy     (busy),
        .dec_done     (done)
    );

    decodificador_secuencial #(
        .SEL_W       (3),
        .HOLD_CYCLES (1)
    ) dut8 (
        .clk          (clk),
        .reset        (reset),
        .dec_enable   (en8),
        .dec_mode     (mode8),
        .dec_valid    (valid8),
        .dec_selector (sel8),
        .dec_ready    (ready8),
        .dec_out      (out8),
        .dec_index    (idx8),
        .dec_busy     (busy8),
        .dec_done     (done8)
    );

    always @(negedge clk) begin
        if (!reset) begin
            n_tests++;
            if (!$onehot0(out)) begin
                n_fail++;
                $display("FAIL onehot4: dec_out=%b, required one-hot or zero", out);
            end
            n_tests++;
            if (!$onehot0(out8)) begin
                n_fail++;
                $display("FAIL onehot8: dec_out=%b, required one-hot or zero", out8);
            end
        end
    end

    function automatic void model_clear();
        mq_out.delete();
        mq_idx.delete();
        m_done = 1'b0;
    endfunction

    // Applies one rising edge to the model using the inputs present at that edge.
    function automatic void model_edge();
        int lines;
        int line;
        if (reset || !en) begin
            model_clear();
        end else if (mq_out.size() == 0) begin
            m_done = 1'b0;
            if (valid) begin
                lines = mode ? OUT_W : 1;
                for (int k = 0; k < lines; k++) begin
                    line = (int'(sel) + k) % OUT_W;
                    for (int h = 0; h < HOLD; h++) begin
                        mq_out.push_back(4'(1 << line));
                        mq_idx.push_back(2'(line));
                    end
                end
            end
        end else begin
            void'(mq_out.pop_front());
            void'(mq_idx.pop_front());
            m_done = (mq_out.size() == 0);
        end
    endfunction

    function automatic void model_view(output logic [3:0] e_out, output logic [1:0] e_idx,
                                       output logic e_busy, output logic e_ready);
        e_busy  = (mq_out.size() != 0);
        e_out   = e_busy ? mq_out[0] : 4'b0000;
        e_idx   = e_busy ? mq_idx[0] : 2'b00;
        e_ready = !e_busy && en;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_tests++;
        if (out !== 4'b0000 || idx !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: out=%b idx=%0d busy=%b done=%b, required 0000/0/0/0",
                     out, idx, busy, done);
        end
        n_tests++;
        if (out8 !== 8'h00 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state8: out=%h busy=%b done=%b, required 00/0/0",
                     out8, busy8, done8);
        end
        reset = 1'b0;
        en    = 1'b1;
        #1;
        n_tests++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: ready=%b, required 1", ready);
        end
    endtask

    task automatic test_direct();
        en = 1'b1; mode = 1'b0; sel = 2'b10; valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            n_tests++;
            if (out !== 4'b0100 || busy !== 1'b1 || done !== 1'b0 || idx !== 2'd2) begin
                n_fail++;
                $display("FAIL direct_hold c%0d: out=%b busy=%b done=%b idx=%0d, required 0100/1/0/2",
                         c, out, busy, done, idx);
            end
            tick();
        end
        n_tests++;
        if (out !== 4'b0000 || done !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL direct_done: out=%b done=%b busy=%b ready=%b, required 0000/1/0/1",
                     out, done, busy, ready);
        end
        tick();
        n_tests++;
        if (done !== 1'b0 || out !== 4'b0000) begin
            n_fail++;
            $display("FAIL direct_after: done=%b out=%b, required 0/0000", done, out);
        end
    endtask

    task automatic test_scan_wrap();
        int line;
        en = 1'b1; mode = 1'b1; sel = 2'b11; valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            line = (3 + c / 3) % 4;
            n_tests++;
            if (out !== 4'(1 << line) || idx !== 2'(line) || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL scan_wrap c%0d: out=%b idx=%0d busy=%b done=%b, required %b/%0d/1/0",
                         c + 1, out, idx, busy, done, 4'(1 << line), line);
            end
            tick();
        end
        n_tests++;
        if (out !== 4'b0000 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL scan_done: out=%b done=%b busy=%b, required 0000/1/0", out, done, busy);
        end
        tick();
    endtask

    task automatic test_abort();
        en = 1'b1; mode = 1'b1; sel = 2'b00; valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        n_tests++;
        if (out !== 4'b0010 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre: out=%b busy=%b, required 0010/1", out, busy);
        end
        en = 1'b0;
        #1;
        n_tests++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_ready: ready=%b, required 0", ready);
        end
        valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++;
            if (out !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || ready !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_idle c%0d: out=%b busy=%b done=%b ready=%b, required 0000/0/0/0",
                         c, out, busy, done, ready);
            end
        end
        valid = 1'b0;
        en    = 1'b1;
        #1;
        n_tests++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reenable: ready=%b, required 1", ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e_out;
        logic [1:0] e_idx;
        logic       e_busy;
        logic       e_ready;
        int         n_done = 0;
        en = 1'b1; mode = 1'b0; valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            sel = c[0] ? 2'b01 : 2'b10;
            tick();
            model_view(e_out, e_idx, e_busy, e_ready);
            n_tests++;
            if (out !== e_out || busy !== e_busy || done !== m_done || ready !== e_ready ||
                (e_busy && idx !== e_idx)) begin
                n_fail++;
                $display("FAIL b2b c%0d: out=%b busy=%b done=%b ready=%b idx=%0d, required %b/%b/%b/%b/%0d",
                         c, out, busy, done, ready, idx, e_out, e_busy, m_done, e_ready, e_idx);
            end
            if (done === 1'b1) n_done++;
        end
        valid = 1'b0;
        n_tests++;
        if (n_done != 4) begin
            n_fail++;
            $display("FAIL b2b_count: done pulses=%0d, required 4", n_done);
        end
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic test_random();
        logic [3:0] e_out;
        logic [1:0] e_idx;
        logic       e_busy;
        logic       e_ready;
        for (int c = 0; c < 300; c++) begin
            en    = ($urandom_range(15) != 0);
            valid = ($urandom_range(2) == 0);
            mode  = 1'($urandom);
            sel   = 2'($urandom);
            tick();
            model_view(e_out, e_idx, e_busy, e_ready);
            n_tests++;
            if (out !== e_out || busy !== e_busy || done !== m_done || ready !== e_ready ||
                (e_busy && idx !== e_idx)) begin
                n_fail++;
                $display("FAIL random c%0d: out=%b busy=%b done=%b ready=%b idx=%0d, required %b/%b/%b/%b/%0d",
                         c, out, busy, done, ready, idx, e_out, e_busy, m_done, e_ready, e_idx);
            end
        end
        en = 1'b1; valid = 1'b0;
        for (int c = 0; c < 14; c++) tick();
    endtask

    task automatic test_reset_midscan();
        en = 1'b1; mode = 1'b1; sel = 2'b01; valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        #3;
        reset = 1'b1;
        #1;
        model_clear();
        n_tests++;
        if (out !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || idx !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_async: out=%b busy=%b done=%b idx=%0d, required 0000/0/0/0",
                     out, busy, done, idx);
        end
        tick();
        reset = 1'b0;
        tick();
        n_tests++;
        if (done !== 1'b0 || out !== 4'b0000 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: done=%b out=%b ready=%b, required 0/0000/1",
                     done, out, ready);
        end
    endtask

    task automatic test_width();
        int line;
        en8 = 1'b1; mode8 = 1'b1; sel8 = 3'b110; valid8 = 1'b1;
        tick();
        valid8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            line = (6 + k) % 8;
            n_tests++;
            if (out8 !== 8'(1 << line) || idx8 !== 3'(line) || busy8 !== 1'b1 || done8 !== 1'b0) begin
                n_fail++;
                $display("FAIL width8 k%0d: out=%h idx=%0d busy=%b done=%b, required %h/%0d/1/0",
                         k, out8, idx8, busy8, done8, 8'(1 << line), line);
            end
            tick();
        end
        n_tests++;
        if (out8 !== 8'h00 || done8 !== 1'b1 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL width8_done: out=%h done=%b busy=%b, required 00/1/0", out8, done8, busy8);
        end
        tick();
        n_tests++;
        if (done8 !== 1'b0) begin
            n_fail++;
            $display("FAIL width8_after: done=%b, required 0", done8);
        end
        en8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan_wrap();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_midscan();
        test_width();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
